buzzer_pattern_gen: RTL and testbench

- Downstream of the NIOS system's buzzer PIO export.
- Converts the CPU's single-bit "alarm ringing" level into an audible square-wave tone, gated into on/off beep bursts.
- Provides a local snooze and an auto-silence timeout, so a stalled CPU cannot ring forever.
- Output drives the passive buzzer pin directly.

---
 rtl/buzzer_pattern_gen_if.sv | 10 +
 rtl/buzzer_pattern_gen.sv | 94 +++++++++
 tb/tb_buzzer_pattern_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/buzzer_pattern_gen_if.sv
// buzzer_pattern_gen_if: CPU-side request/snooze inputs and buzzer-side status outputs.
interface buzzer_pattern_gen_if;
  logic buzzer_req;
  logic snooze;
  logic buzzer_pwm;
  logic beep_active;
  logic timed_out;
  modport master(output buzzer_req, snooze, input buzzer_pwm, beep_active, timed_out);
  modport slave(input buzzer_req, snooze, output buzzer_pwm, beep_active, timed_out);
endinterface

// File: rtl/buzzer_pattern_gen.sv
// buzzer_pattern_gen: turns the alarm level into gated 50% tone bursts with snooze and auto-silence.
module buzzer_pattern_gen #(
  parameter int TONE_HALF_CYC = 12500,
  parameter int ON_CYC = 12500000,
  parameter int OFF_CYC = 12500000,
  parameter int BURSTS_MAX = 240
) (
  input logic clk_clk,
  input logic reset_reset,
  buzzer_pattern_gen_if.slave bus
);
  localparam int PMAX = ON_CYC > OFF_CYC ? ON_CYC : OFF_CYC;
  localparam int TW = TONE_HALF_CYC > 1 ? $clog2(TONE_HALF_CYC) : 1;
  localparam int PW = PMAX > 1 ? $clog2(PMAX) : 1;
  localparam int BW = BURSTS_MAX > 0 ? $clog2(BURSTS_MAX + 1) : 1;
  typedef enum logic [1:0] {IDLE, TONE_ON, TONE_OFF, MUTED} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d, burst_nxt;
  logic pwm_q, pwm_d, active_q, active_d, to_q, to_d;
  logic ringing, hit;
  always_comb begin
    state_d = state_q;
    tone_cnt_d = tone_cnt_q;
    phase_cnt_d = phase_cnt_q;
    burst_cnt_d = burst_cnt_q;
    pwm_d = pwm_q;
    to_d = to_q;
    ringing = state_q == TONE_ON || state_q == TONE_OFF;
    // saturating so a disabled timeout never wraps the burst count
    burst_nxt = &burst_cnt_q ? burst_cnt_q : burst_cnt_q + BW'(1);
    hit = BURSTS_MAX != 0 && burst_nxt == BW'(BURSTS_MAX);
    if (state_q == IDLE) begin
      if (bus.buzzer_req) begin
        state_d = TONE_ON;
        pwm_d = 1'b1;
        tone_cnt_d = '0;
        phase_cnt_d = '0;
        burst_cnt_d = '0;
      end
    end else if (!bus.buzzer_req) begin
      state_d = IDLE;
      pwm_d = 1'b0;
      to_d = 1'b0;
      tone_cnt_d = '0;
      phase_cnt_d = '0;
    end else if (ringing && bus.snooze) begin
      state_d = MUTED;
      pwm_d = 1'b0;
    end else if (state_q == TONE_ON) begin
      if (phase_cnt_q == PW'(ON_CYC - 1)) begin
        state_d = hit ? MUTED : TONE_OFF;
        to_d = hit;
        burst_cnt_d = burst_nxt;
        pwm_d = 1'b0;
        tone_cnt_d = '0;
        phase_cnt_d = '0;
      end else begin
        phase_cnt_d = phase_cnt_q + PW'(1);
        tone_cnt_d = tone_cnt_q == TW'(TONE_HALF_CYC - 1) ? '0 : tone_cnt_q + TW'(1);
        pwm_d = tone_cnt_q == TW'(TONE_HALF_CYC - 1) ? ~pwm_q : pwm_q;
      end
    end else if (state_q == TONE_OFF) begin
      state_d = phase_cnt_q == PW'(OFF_CYC - 1) ? TONE_ON : TONE_OFF;
      pwm_d = phase_cnt_q == PW'(OFF_CYC - 1);
      phase_cnt_d = phase_cnt_q == PW'(OFF_CYC - 1) ? '0 : phase_cnt_q + PW'(1);
      tone_cnt_d = '0;
    end
    active_d = state_d == TONE_ON || state_d == TONE_OFF;
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      tone_cnt_q <= '0;
      phase_cnt_q <= '0;
      burst_cnt_q <= '0;
      pwm_q <= 1'b0;
      active_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tone_cnt_q <= tone_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      pwm_q <= pwm_d;
      active_q <= active_d;
      to_q <= to_d;
    end
  end
  assign bus.buzzer_pwm = pwm_q;
  assign bus.beep_active = active_q;
  assign bus.timed_out = to_q;
endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// tb_buzzer_pattern_gen: directed and random checks against a time-since-ring-start model.
module tb_buzzer_pattern_gen;
  localparam int H = 2, ON = 8, OFF = 4, BM = 3, PER = ON + OFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  buzzer_pattern_gen_if bus();
  buzzer_pattern_gen #(.TONE_HALF_CYC(H), .ON_CYC(ON), .OFF_CYC(OFF), .BURSTS_MAX(BM)) dut (
    .clk_clk(clk), .reset_reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int mode = 0, t = 0;
  bit mto = 0;
  logic [2:0] obs, exp_o;
  function automatic logic [2:0] model_out();
    int pos;
    logic pwm;
    pos = t % PER;
    pwm = mode == 1 && pos < ON && ((pos / H) % 2 == 0);
    return {pwm, mode == 1, mto};
  endfunction
  task automatic step(input logic r, input logic s);
    bus.buzzer_req = r;
    bus.snooze = s;
    @(posedge clk);
    if (mode == 0) begin
      if (r) begin mode = 1; t = 0; end
    end else if (!r) begin
      mode = 0; mto = 0;
    end else if (mode == 1 && s) begin
      mode = 2;
    end else if (mode == 1) begin
      t++;
      if (BM != 0 && t == BM * PER - OFF) begin mode = 2; mto = 1; end
    end
    #1;
    obs = {bus.buzzer_pwm, bus.beep_active, bus.timed_out};
    exp_o = model_out();
  endtask
  task automatic do_reset();
    bus.buzzer_req = 1'b0;
    bus.snooze = 1'b0;
    rst = 1'b1;
    mode = 0; mto = 0; t = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    obs = {bus.buzzer_pwm, bus.beep_active, bus.timed_out};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", obs); end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs !== 3'b000) begin errors++; $display("FAIL idle_quiet cyc%0d: got %b expected 000", i, obs); end
    end
  endtask
  task automatic test_tone_pattern();
    int exp_pwm[13] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    int exp_act[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs[2] !== exp_pwm[c-1][0] || obs[1] !== exp_act[c-1][0] || obs[0] !== 1'b0) begin
        errors++;
        $display("FAIL tone_pattern cyc%0d: got %b expected pwm=%0d act=%0d to=0", c, obs, exp_pwm[c-1], exp_act[c-1]);
      end
    end
  endtask
  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL timeout_ring cyc%0d: got %b expected %b", c, obs, exp_o); end
      if (c == 33 || c == 40) begin
        checks++;
        if (obs !== 3'b001) begin errors++; $display("FAIL timeout_muted cyc%0d: got %b expected 001", c, obs); end
      end
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL timeout_clear: got %b expected 000", obs); end
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL timeout_rearm: got %b expected 110", obs); end
  endtask
  task automatic test_snooze();
    do_reset();
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL snooze_mute: got %b expected 000", obs); end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== 3'b000) begin errors++; $display("FAIL snooze_hold cyc%0d: got %b expected 000", i, obs); end
    end
  endtask
  task automatic test_simultaneous();
    do_reset();
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL drop_idle: got %b expected 000", obs); end
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (obs !== 3'b000 || obs !== exp_o) begin errors++; $display("FAIL drop_snooze_idle: got %b expected 000", obs); end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL drop_snooze_rearm: got %b expected 110", obs); end
    repeat (31) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL snooze_at_timeout: got %b expected 000", obs); end
  endtask
  task automatic test_async_reset();
    do_reset();
    repeat (2) step(1'b1, 1'b0);
    #2 rst = 1'b1;
    mode = 0; mto = 0;
    #1 obs = {bus.buzzer_pwm, bus.beep_active, bus.timed_out};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL async_reset: got %b expected 000", obs); end
    @(posedge clk);
    #2 rst = 1'b0;
    obs = {bus.buzzer_pwm, bus.beep_active, bus.timed_out};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL reset_release: got %b expected 000", obs); end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL reset_resume: got %b expected 110", obs); end
  endtask
  task automatic test_random();
    logic r, s;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 24) != 0;
      s = $urandom_range(0, 40) == 0;
      step(r, s);
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL random cyc%0d req=%b snz=%b: got %b expected %b", i, r, s, obs, exp_o); end
    end
  endtask
  initial begin
    bus.buzzer_req = 1'b0;
    bus.snooze = 1'b0;
    test_reset();
    test_tone_pattern();
    test_timeout();
    test_snooze();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
